// File: rtl/sm_mem_arb_2to1.sv
// Round-robin 2:1 arbiter sharing one mem port; responses routed in order via an in-flight port-ID FIFO.
// Zero-latency combinational request/response paths; the only state is prio, the ID FIFO and the count.
// Requests stall when p_max_inflight are outstanding; response rdy follows the head requester. SM_MEM_ARB_STATS_EN adds counters.
module sm_mem_arb_2to1 #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_max_inflight = 4,
    localparam int c_len_nbits  = $clog2(p_data_nbits / 8),
    localparam int c_req_nbits  = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits + p_data_nbits,
    localparam int c_resp_nbits = 3 + p_opaque_nbits + 2 + c_len_nbits + p_data_nbits,
    localparam int c_ptr_nbits  = $clog2(p_max_inflight),
    localparam int c_cnt_nbits  = c_ptr_nbits + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [c_req_nbits-1:0]  req0_msg,
    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [c_req_nbits-1:0]  req1_msg,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [c_resp_nbits-1:0] resp0_msg,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [c_resp_nbits-1:0] resp1_msg,
    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic [c_req_nbits-1:0]  memreq_msg,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [c_resp_nbits-1:0] memresp_msg,
    output logic [c_cnt_nbits-1:0]  outstanding
`ifdef SM_MEM_ARB_STATS_EN
    ,
    output logic [31:0]             grant0_count,
    output logic [31:0]             grant1_count,
    output logic [31:0]             full_stall_count
`endif
);

    logic                      prio;
    logic [p_max_inflight-1:0] id_fifo;
    logic [c_ptr_nbits-1:0]    head_ptr;
    logic [c_ptr_nbits-1:0]    tail_ptr;
    logic [c_cnt_nbits-1:0]    count;
    logic                      full;
    logic                      empty;
    logic                      winner;
    logic                      head_id;
    logic                      push;
    logic                      pop;

    assign full    = (count == c_cnt_nbits'(p_max_inflight));
    assign empty   = (count == '0);
    // With a single valid port that port wins; prio only breaks ties.
    assign winner  = (req0_val && req1_val) ? prio : req1_val;
    assign head_id = id_fifo[head_ptr];

    always_comb begin
        memreq_val  = reset && (req0_val || req1_val) && !full;
        memreq_msg  = winner ? req1_msg : req0_msg;
        req0_rdy    = reset && memreq_rdy && !full && !winner;
        req1_rdy    = reset && memreq_rdy && !full && winner;
        memresp_rdy = reset && !empty && (head_id ? resp1_rdy : resp0_rdy);
        resp0_val   = reset && memresp_val && !empty && !head_id;
        resp1_val   = reset && memresp_val && !empty && head_id;
    end

    assign resp0_msg   = memresp_msg;
    assign resp1_msg   = memresp_msg;
    assign push        = memreq_val && memreq_rdy;
    assign pop         = memresp_val && memresp_rdy;
    assign outstanding = count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio     <= 1'b0;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + 1'b1;
                prio     <= ~winner;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push) begin
            id_fifo[tail_ptr] <= winner;
        end
    end

`ifdef SM_MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant0_count     <= '0;
            grant1_count     <= '0;
            full_stall_count <= '0;
        end else begin
            if (push && !winner && grant0_count != '1) begin
                grant0_count <= grant0_count + 32'd1;
            end
            if (push && winner && grant1_count != '1) begin
                grant1_count <= grant1_count + 32'd1;
            end
            if ((req0_val || req1_val) && full && full_stall_count != '1) begin
                full_stall_count <= full_stall_count + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && memresp_val && empty) begin
            $display("sm_mem_arb_2to1: protocol error, memresp_val with no request in flight");
        end
    end
`endif

endmodule

// File: tb/tb_sm_mem_arb_2to1.sv
// Scoreboarded bench for sm_mem_arb_2to1: behavioural in-order memory, per-port expected response queues.
module tb_sm_mem_arb_2to1;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opq;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } req_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opq;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        resp_t msg;
        int    rdy_cyc;
    } pend_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       req0_val, req0_rdy, req1_val, req1_rdy;
    req_t       req0_msg, req1_msg, memreq_msg;
    logic       resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    resp_t      resp0_msg, resp1_msg;
    logic       memreq_val;
    logic       memreq_rdy  = 1'b1;
    logic       memresp_val = 1'b0;
    logic       memresp_rdy;
    resp_t      memresp_msg = '0;
    logic [2:0] outstanding;
`ifdef SM_MEM_ARB_STATS_EN
    logic [31:0] grant0_count, grant1_count, full_stall_count;
`endif

    sm_mem_arb_2to1 dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
        .outstanding(outstanding)
`ifdef SM_MEM_ARB_STATS_EN
        , .grant0_count(grant0_count), .grant1_count(grant1_count), .full_stall_count(full_stall_count)
`endif
    );

    int          vectors = 0;
    int          miscompares = 0;
    resp_t       exp_q[2][$];
    resp_t       obs_q[2][$];
    int          obs_rd[2];
    req_t        grant_log[$];
    int          resp1_cnt = 0;
    logic [6:0]  seq[2];
    logic [31:0] gold[int];
    logic [31:0] mem_arr[int];
    pend_t       pend[$];
    int          cyc = 0;
    int          mem_max_delay = 0;
    int          mem_rdy_pct = 100;
    bit          mem_resp_en = 1'b1;
    int          credits_given = 0;
    int          credits_used = 0;
    bit          fifth_done;
    bit [1:0]    src_done;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Memory model and monitor: sample on negedge, update memory-side drive 2 ns after posedge.
    always begin
        bit    rq_fire, rs_fire;
        req_t  rq;
        pend_t e;
        int    idx;
        @(negedge clk);
        rq_fire = memreq_val && memreq_rdy;
        rs_fire = memresp_val && memresp_rdy;
        rq = memreq_msg;
        if (rq_fire) grant_log.push_back(rq);
        if (resp0_val && resp0_rdy) obs_q[0].push_back(resp0_msg);
        if (resp1_val && resp1_rdy) obs_q[1].push_back(resp1_msg);
        if (resp1_val) resp1_cnt++;
        @(posedge clk);
        cyc++;
        #2;
        if (!reset) begin
            pend.delete();
        end else begin
            if (rs_fire && pend.size() > 0) begin
                void'(pend.pop_front());
                if (!mem_resp_en) credits_used++;
            end
            if (rq_fire) begin
                idx = int'(rq.addr[9:2]);
                e.msg.typ = rq.typ; e.msg.opq = rq.opq; e.msg.test = 2'b00; e.msg.len = rq.len;
                if (rq.typ == 3'd1) begin
                    mem_arr[idx] = rq.data;
                    e.msg.data = '0;
                end else begin
                    e.msg.data = mem_arr.exists(idx) ? mem_arr[idx] : init_word(idx);
                end
                e.rdy_cyc = cyc + int'($urandom_range(0, mem_max_delay));
                if (pend.size() > 0 && pend[$].rdy_cyc > e.rdy_cyc) e.rdy_cyc = pend[$].rdy_cyc;
                pend.push_back(e);
            end
        end
        memresp_val = (pend.size() > 0) && (pend[0].rdy_cyc <= cyc) && (mem_resp_en || credits_given > credits_used);
        memresp_msg = (pend.size() > 0) ? pend[0].msg : '0;
        memreq_rdy  = ($urandom_range(0, 99) < mem_rdy_pct);
    end

    // Build a request, push its golden response, then hold val until the handshake.
    task automatic issue(input int p, input logic [2:0] typ, input int idx, input logic [31:0] wdata);
        req_t  m;
        resp_t e;
        bit    got;
        int    t;
        m.typ = typ; m.opq = {p[0], seq[p]}; m.addr = 32'(idx * 4); m.len = 2'b00;
        m.data = (typ == 3'd1) ? wdata : '0;
        seq[p] = seq[p] + 7'd1;
        e.typ = typ; e.opq = m.opq; e.test = 2'b00; e.len = 2'b00;
        if (typ == 3'd1) begin
            gold[idx] = wdata;
            e.data = '0;
        end else begin
            e.data = gold.exists(idx) ? gold[idx] : init_word(idx);
        end
        exp_q[p].push_back(e);
        if (p == 0) begin req0_val = 1'b1; req0_msg = m; end
        else begin req1_val = 1'b1; req1_msg = m; end
        got = 1'b0; t = 0;
        while (!got && t < 500) begin
            @(negedge clk);
            got = (p == 0) ? req0_rdy : req1_rdy;
            @(posedge clk); #1;
            t++;
        end
        if (p == 0) req0_val = 1'b0; else req1_val = 1'b0;
        vectors++;
        if (!got) begin miscompares++; $display("FAIL handshake port%0d: rdy=0 for 500 cycles, required 1", p); end
    endtask

    task automatic drain(input int n0, input int n1);
        int t = 0;
        while ((obs_q[0].size() - obs_rd[0] < n0 || obs_q[1].size() - obs_rd[1] < n1) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req0_val = 1'b1; req1_val = 1'b1; req0_msg = '0; req1_msg = '0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL reset_outstanding: got %0d required 0", outstanding); end
        vectors++; if (memreq_val !== 1'b0) begin miscompares++; $display("FAIL reset_memreq_val: got %b required 0", memreq_val); end
        vectors++; if ({req0_rdy, req1_rdy} !== 2'b00) begin miscompares++; $display("FAIL reset_req_rdy: got %b required 00", {req0_rdy, req1_rdy}); end
        vectors++; if ({resp0_val, resp1_val, memresp_rdy} !== 3'b000) begin miscompares++; $display("FAIL reset_resp: got %b required 000", {resp0_val, resp1_val, memresp_rdy}); end
        @(posedge clk); #1;
        req0_val = 1'b0; req1_val = 1'b0; reset = 1'b1;
        @(negedge clk);
        vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL post_reset_outstanding: got %0d required 0", outstanding); end
        vectors++; if (memreq_val !== 1'b0) begin miscompares++; $display("FAIL idle_memreq_val: got %b required 0", memreq_val); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_port();
        int gbase = grant_log.size();
        int r1base = resp1_cnt;
        for (int i = 0; i < 3; i++) issue(0, 3'd0, i, 32'd0);
        drain(3, 0);
        vectors++; if (grant_log.size() - gbase != 3) begin miscompares++; $display("FAIL single_grants: got %0d required 3", grant_log.size() - gbase); end
        for (int i = 0; i < 3 && gbase + i < grant_log.size(); i++) begin
            vectors++;
            if (grant_log[gbase + i].addr !== 32'(i * 4) || grant_log[gbase + i].opq[7] !== 1'b0) begin
                miscompares++; $display("FAIL single_memreq%0d: got addr %h port %b required addr %h port 0", i, grant_log[gbase + i].addr, grant_log[gbase + i].opq[7], i * 4);
            end
        end
        vectors++; if (resp1_cnt != r1base) begin miscompares++; $display("FAIL single_resp1_val: got %0d cycles required 0", resp1_cnt - r1base); end
        @(negedge clk);
        vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL single_outstanding: got %0d required 0", outstanding); end
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) begin
            vectors++;
            if (obs_q[p].size() - obs_rd[p] != exp_q[p].size()) begin miscompares++; $display("FAIL single_count port%0d: got %0d required %0d", p, obs_q[p].size() - obs_rd[p], exp_q[p].size()); end
            while (exp_q[p].size() > 0 && obs_rd[p] < obs_q[p].size()) begin
                resp_t e, o;
                e = exp_q[p].pop_front(); o = obs_q[p][obs_rd[p]]; obs_rd[p]++;
                vectors++; if (o !== e) begin miscompares++; $display("FAIL single_resp port%0d: got %h required %h", p, o, e); end
            end
            exp_q[p].delete(); obs_rd[p] = obs_q[p].size();
        end
    endtask

    task automatic test_contention();
        int gbase;
        apply_reset();
        gbase = grant_log.size();
        fork
            begin for (int i = 0; i < 8; i++) issue(0, 3'd0, 40 + i, 32'd0); end
            begin for (int j = 0; j < 8; j++) issue(1, 3'd0, 168 + j, 32'd0); end
        join
        drain(8, 8);
        vectors++; if (grant_log.size() - gbase != 16) begin miscompares++; $display("FAIL contention_grants: got %0d required 16", grant_log.size() - gbase); end
        for (int i = 0; i < 16 && gbase + i < grant_log.size(); i++) begin
            vectors++;
            if (grant_log[gbase + i].opq[7] !== 1'(i & 1)) begin
                miscompares++; $display("FAIL contention_order grant%0d: got port %b required port %0d", i, grant_log[gbase + i].opq[7], i & 1);
            end
        end
        for (int p = 0; p < 2; p++) begin
            vectors++;
            if (obs_q[p].size() - obs_rd[p] != exp_q[p].size()) begin miscompares++; $display("FAIL contention_count port%0d: got %0d required %0d", p, obs_q[p].size() - obs_rd[p], exp_q[p].size()); end
            while (exp_q[p].size() > 0 && obs_rd[p] < obs_q[p].size()) begin
                resp_t e, o;
                e = exp_q[p].pop_front(); o = obs_q[p][obs_rd[p]]; obs_rd[p]++;
                vectors++; if (o !== e) begin miscompares++; $display("FAIL contention_resp port%0d: got %h required %h", p, o, e); end
            end
            exp_q[p].delete(); obs_rd[p] = obs_q[p].size();
        end
    endtask

    task automatic test_full();
        mem_resp_en = 1'b0;
        for (int i = 0; i < 4; i++) issue(0, 3'd0, 10 + i, 32'd0);
        fifth_done = 1'b0;
        fork
            begin issue(0, 3'd0, 14, 32'd0); fifth_done = 1'b1; end
        join_none
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if ({outstanding, memreq_val, req0_rdy} !== {3'd4, 1'b0, 1'b0}) begin
                miscompares++; $display("FAIL full_stall cyc%0d: got outstanding=%0d memreq_val=%b req0_rdy=%b required 4/0/0", c, outstanding, memreq_val, req0_rdy);
            end
            @(posedge clk); #1;
        end
        credits_given++;
        @(negedge clk);
        vectors++; if ({memresp_rdy, req0_rdy} !== 2'b10) begin miscompares++; $display("FAIL full_release: got memresp_rdy=%b req0_rdy=%b required 1/0", memresp_rdy, req0_rdy); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if ({outstanding, req0_rdy} !== {3'd3, 1'b1}) begin miscompares++; $display("FAIL full_reopen: got outstanding=%0d req0_rdy=%b required 3/1", outstanding, req0_rdy); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if ({outstanding, memresp_val} !== {3'd4, 1'b0}) begin miscompares++; $display("FAIL full_refill: got outstanding=%0d memresp_val=%b required 4/0", outstanding, memresp_val); end
        @(posedge clk); #1;
        vectors++; if (!fifth_done) begin miscompares++; $display("FAIL full_fifth_req: done=0 required 1"); end
        mem_resp_en = 1'b1;
        drain(5, 0);
        for (int p = 0; p < 2; p++) begin
            vectors++;
            if (obs_q[p].size() - obs_rd[p] != exp_q[p].size()) begin miscompares++; $display("FAIL full_count port%0d: got %0d required %0d", p, obs_q[p].size() - obs_rd[p], exp_q[p].size()); end
            while (exp_q[p].size() > 0 && obs_rd[p] < obs_q[p].size()) begin
                resp_t e, o;
                e = exp_q[p].pop_front(); o = obs_q[p][obs_rd[p]]; obs_rd[p]++;
                vectors++; if (o !== e) begin miscompares++; $display("FAIL full_resp port%0d: got %h required %h", p, o, e); end
            end
            exp_q[p].delete(); obs_rd[p] = obs_q[p].size();
        end
    endtask

    task automatic test_resp_backpressure();
        mem_resp_en = 1'b0; resp0_rdy = 1'b1; resp1_rdy = 1'b0;
        issue(1, 3'd0, 130, 32'd0);
        issue(0, 3'd0, 20, 32'd0);
        mem_resp_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++; if ({memresp_rdy, resp0_val, resp1_val} !== 3'b001) begin
                miscompares++; $display("FAIL bp_hold cyc%0d: got memresp_rdy=%b resp0_val=%b resp1_val=%b required 0/0/1", c, memresp_rdy, resp0_val, resp1_val);
            end
            @(posedge clk); #1;
        end
        vectors++; if (obs_q[1].size() != obs_rd[1]) begin miscompares++; $display("FAIL bp_early: got %0d responses required 0", obs_q[1].size() - obs_rd[1]); end
        resp1_rdy = 1'b1;
        @(negedge clk);
        vectors++; if ({memresp_rdy, resp1_val} !== 2'b11) begin miscompares++; $display("FAIL bp_release: got memresp_rdy=%b resp1_val=%b required 1/1", memresp_rdy, resp1_val); end
        @(posedge clk); #1;
        drain(1, 1);
        for (int p = 0; p < 2; p++) begin
            vectors++;
            if (obs_q[p].size() - obs_rd[p] != exp_q[p].size()) begin miscompares++; $display("FAIL bp_count port%0d: got %0d required %0d", p, obs_q[p].size() - obs_rd[p], exp_q[p].size()); end
            while (exp_q[p].size() > 0 && obs_rd[p] < obs_q[p].size()) begin
                resp_t e, o;
                e = exp_q[p].pop_front(); o = obs_q[p][obs_rd[p]]; obs_rd[p]++;
                vectors++; if (o !== e) begin miscompares++; $display("FAIL bp_resp port%0d: got %h required %h", p, o, e); end
            end
            exp_q[p].delete(); obs_rd[p] = obs_q[p].size();
        end
    endtask

    task automatic test_reset_midrun();
        mem_resp_en = 1'b0;
        issue(0, 3'd0, 30, 32'd0);
        issue(0, 3'd0, 31, 32'd0);
        @(negedge clk);
        vectors++; if (outstanding !== 3'd2) begin miscompares++; $display("FAIL midrun_inflight: got %0d required 2", outstanding); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q[0].delete(); exp_q[1].delete();
        obs_rd[0] = obs_q[0].size(); obs_rd[1] = obs_q[1].size();
        mem_resp_en = 1'b1;
        @(negedge clk);
        vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL midrun_outstanding: got %0d required 0", outstanding); end
        @(posedge clk); #1;
        fork
            issue(1, 3'd0, 140, 32'd0);
        join_none
        @(negedge clk);
        vectors++; if ({req1_rdy, memreq_val} !== 2'b11) begin miscompares++; $display("FAIL midrun_req1_grant: got req1_rdy=%b memreq_val=%b required 1/1", req1_rdy, memreq_val); end
        @(posedge clk); #1;
        drain(0, 1);
        for (int p = 0; p < 2; p++) begin
            vectors++;
            if (obs_q[p].size() - obs_rd[p] != exp_q[p].size()) begin miscompares++; $display("FAIL midrun_count port%0d: got %0d required %0d", p, obs_q[p].size() - obs_rd[p], exp_q[p].size()); end
            while (exp_q[p].size() > 0 && obs_rd[p] < obs_q[p].size()) begin
                resp_t e, o;
                e = exp_q[p].pop_front(); o = obs_q[p][obs_rd[p]]; obs_rd[p]++;
                vectors++; if (o !== e) begin miscompares++; $display("FAIL midrun_resp port%0d: got %h required %h", p, o, e); end
            end
            exp_q[p].delete(); obs_rd[p] = obs_q[p].size();
        end
    endtask

    task automatic test_random();
        mem_max_delay = 3; mem_rdy_pct = 70; src_done = 2'b00;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    issue(0, ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd0, int'($urandom_range(0, 15)), $urandom);
                end
                src_done[0] = 1'b1;
            end
            begin
                for (int j = 0; j < 100; j++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    issue(1, ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd0, 128 + int'($urandom_range(0, 15)), $urandom);
                end
                src_done[1] = 1'b1;
            end
            begin
                while (src_done != 2'b11) begin
                    resp0_rdy = ($urandom_range(0, 3) != 0);
                    resp1_rdy = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                resp0_rdy = 1'b1; resp1_rdy = 1'b1;
            end
        join
        drain(exp_q[0].size(), exp_q[1].size());
        mem_max_delay = 0; mem_rdy_pct = 100;
        for (int p = 0; p < 2; p++) begin
            vectors++;
            if (obs_q[p].size() - obs_rd[p] != exp_q[p].size()) begin miscompares++; $display("FAIL random_count port%0d: got %0d required %0d", p, obs_q[p].size() - obs_rd[p], exp_q[p].size()); end
            while (exp_q[p].size() > 0 && obs_rd[p] < obs_q[p].size()) begin
                resp_t e, o;
                e = exp_q[p].pop_front(); o = obs_q[p][obs_rd[p]]; obs_rd[p]++;
                vectors++; if (o !== e) begin miscompares++; $display("FAIL random_resp port%0d: got %h required %h", p, o, e); end
            end
            exp_q[p].delete(); obs_rd[p] = obs_q[p].size();
        end
    endtask

    initial begin
        reset = 1'b0;
        req0_val = 1'b0; req1_val = 1'b0; req0_msg = '0; req1_msg = '0;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        seq[0] = '0; seq[1] = '0; obs_rd[0] = 0; obs_rd[1] = 0;
        @(posedge clk); #1;
        test_reset();
        test_single_port();
        test_contention();
        test_full();
        test_resp_backpressure();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sm_mem_arb_2to1.md
Name: sm_mem_arb_2to1

Overview:
- Shares one single-ported memory (test memory or cache port) between two requesters (e.g. instruction and data ports of a core).
- Round-robin arbitration of the two request streams onto one memreq port.
- In-order routing of memory responses back to the originating requester via an internal in-flight port-ID FIFO.
- Messages use the standard sm mem request/response formats and pass through unmodified; the opaque field is not rewritten.

Parameters:
- p_opaque_nbits, 8, mem message opaque field bits
- p_addr_nbits, 32, mem message address bits
- p_data_nbits, 32, mem message data bits
- p_max_inflight, 4, depth of in-flight FIFO (max outstanding requests); power of two, >=2
- c_req_nbits, SM_MEM_REQ_MSG_NBITS(o,a,d), derived, not set externally
- c_resp_nbits, SM_MEM_RESP_MSG_NBITS(o,d), derived, not set externally

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset; sampled on rising clk, reset==0 resets
- req0_val  in  1  requester 0 request valid
- req0_rdy  out  1  requester 0 request ready
- req0_msg  in  c_req_nbits  requester 0 request
- req1_val  in  1  requester 1 request valid
- req1_rdy  out  1  requester 1 request ready
- req1_msg  in  c_req_nbits  requester 1 request
- resp0_val  out  1  response valid to requester 0
- resp0_rdy  in  1  requester 0 response ready
- resp0_msg  out  c_resp_nbits  response to requester 0
- resp1_val  out  1  response valid to requester 1
- resp1_rdy  in  1  requester 1 response ready
- resp1_msg  out  c_resp_nbits  response to requester 1
- memreq_val  out  1  request valid to memory
- memreq_rdy  in  1  memory request ready
- memreq_msg  out  c_req_nbits  request to memory
- memresp_val  in  1  memory response valid
- memresp_rdy  out  1  memory response ready
- memresp_msg  in  c_resp_nbits  memory response
- outstanding  out  clog2(p_max_inflight)+1  count of in-flight requests

Behaviour:
- State: priority pointer prio (1 bit; 0 = port 0 favoured), in-flight FIFO (p_max_inflight x 1 bit port IDs, head/tail pointers), outstanding counter.
- Reset (reset==0 at posedge): prio=0, FIFO empty, outstanding=0. Any requests and responses in flight at reset time are dropped. All val/rdy outputs are 0 while reset==0.
- Request arbitration (combinational, zero latency):
  - full = (outstanding == p_max_inflight).
  - If both reqN_val are asserted, the winner is prio; otherwise the winner is the single valid port.
  - memreq_val = (req0_val | req1_val) & !full.
  - memreq_msg = winner's msg, passed bit-exact.
  - rdy to winner = memreq_rdy & !full; the loser's rdy = 0.
  - req rdy must not depend on the same port's val combinationally beyond the winner select; there is no path from memresp to memreq.
- On a request handshake: push the winner ID into the FIFO tail; prio <= ~winner (loser favoured next). With no handshake, prio holds; a stalled winner keeps the grant while its val stays high.
- Response routing:
  - head = FIFO head ID when not empty.
  - respH_val = memresp_val & !empty; the other port's resp_val = 0.
  - respN_msg = memresp_msg for both ports; only the val gates delivery.
  - memresp_rdy = respH_rdy & !empty.
  - On a response handshake, pop the FIFO.
- A memresp_val while the FIFO is empty is a protocol error: memresp_rdy = 0, nothing popped, and a simulation $display error is printed (non-synth).
- outstanding increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop. A push is blocked when full, even if a pop happens in the same cycle; this keeps rdy free of a memresp dependency.
- FIFO pointers wrap modulo p_max_inflight.
- Memory is required to return responses in request order.

Optional Feature:
- Macro SM_MEM_ARB_STATS_EN.
- Defined: adds outputs grant0_count[31:0], grant1_count[31:0] (request handshakes per port) and full_stall_count[31:0] (cycles with any req val && full). All three are saturating at 32'hFFFFFFFF and cleared by reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single port: 3 reads on req0 from addrs 0x0/0x4/0x8, memory 0-delay -> 3 memreqs in order, resp0 gets 3 responses, resp1_val never 1, outstanding returns to 0.
- Contention: req0 and req1 both val every cycle for 8 requests each, memreq_rdy=1 -> grants alternate 0,1,0,1...; each port receives its 8 responses with matching opaque.
- Full: p_max_inflight=4, memresp held off -> 4 handshakes, then memreq_val=0 and req rdy=0; releasing 1 response -> rdy reasserts the next cycle, outstanding goes 4->3->4.
- Response backpressure: head=port1 with resp1_rdy=0 for 5 cycles -> memresp_rdy=0 and resp0_val=0 throughout; response delivered on the cycle resp1_rdy=1.
- Reset mid-run: reset=0 with 2 in flight -> outstanding=0 and prio=0 next cycle; then req1 only -> granted immediately.
- Random: random max_delay on memory plus random source/sink delays, 200 mixed reads/writes -> all responses match golden data per port.
